conv_window_buffer: RTL and testbench
=====================================

# conv_window_buffer

Parametrised, double-buffered K×K convolution window store for the YOLOv7 conv datapath. It accepts window elements one at a time over a valid/ready stream, with each element carrying CH channels. It captures the window's pixel coordinates and image-edge flags alongside the centre element. A completed window is presented as one packed word on a valid/ready output, while the next window fills the other bank, so loading and consumption overlap without stalls.

## Interface
Parameters:
- DATA_W, 8, bits per channel sample
- K, 3, kernel side; must be odd and ≥3 (elaboration error otherwise)
- CH, 1, channels per window element
- COORD_W, 15, width of the row and column coordinates
- CNT_W, 16, width of the emitted-window counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  element present
- in_ready  out  1  element can be accepted
- in_data  in  CH*DATA_W  element; channel 0 in MSBs
- in_row  in  COORD_W  row coordinate, sampled with the centre element
- in_col  in  COORD_W  column coordinate, sampled with the centre element
- in_edge  in  4  {zero_row, final_row, zero_col, final_col}, sampled with the centre element
- flush  in  1  discard the partially filled window
- out_valid  out  1  complete window available
- out_ready  in  1  consumer accepts the window
- out_window  out  K*K*CH*DATA_W  element 0 in MSBs, element K*K-1 in LSBs
- out_row, out_col  out  COORD_W  captured coordinates
- out_edge  out  4  captured edge flags
- win_count  out  CNT_W  number of windows consumed; wraps modulo 2^CNT_W

## Operation
- Two banks, A and B. Each bank holds K*K elements, its metadata and a full flag. A write pointer (wr_bank) and a read pointer (rd_bank) each toggle between the banks. Both pointers reset to A.
- Accept: an element is accepted when in_valid && in_ready. It is stored at index fill_idx of wr_bank, and fill_idx then increments.
- Metadata capture: when fill_idx == C, where C = (K*K-1)/2, in_row, in_col and in_edge are captured into wr_bank.
- Bank completion: when fill_idx == K*K-1 is accepted:
  - wr_bank.full is set.
  - fill_idx returns to 0.
  - wr_bank toggles.
- in_ready = reset deasserted && !wr_bank.full. The signal is combinational from the bank flags.
- Output side:
  - out_valid = rd_bank.full.
  - out_window and the out_* metadata are driven directly from the rd_bank registers.
- Consume: on out_valid && out_ready, rd_bank.full clears, rd_bank toggles and win_count increments.
- flush:
  - Resets fill_idx to 0 and discards the metadata already captured for the partial window.
  - Has no effect on full banks or on the output side.
  - An element offered in the same cycle as flush is dropped, and in_ready stays as computed.
- Out-of-range data never occurs: indices are fully bounded by K*K.

## Timing
- Reset values:
  - in_ready=0 while reset is low, then 1 on the first cycle after release.
  - out_valid=0, out_window=0, out_row=0, out_col=0, out_edge=0, win_count=0.
  - fill_idx=0, both full flags=0.
- Latency: when the last element is accepted in cycle N, out_valid=1 in cycle N+1.
- Output stability: while out_valid && !out_ready, all out_* fields hold stable.
- Both banks full: in_ready=0 until a consume occurs. In the cycle after that consume, in_ready=1.
- Simultaneous completion and consume: permitted when the banks are different. Both flag updates take effect on the same edge.
- Reset mid-fill or mid-output: all state clears and the partial window is lost. Storage contents are not cleared; only the output word is forced to 0 through the cleared full flags gating out_window.
- out_window = 0 whenever out_valid = 0.

## Structure
- Shared package conv_pkg:
  - Edge-flag bit index constants: ZERO_ROW=3, FINAL_ROW=2, ZERO_COL=1, FINAL_COL=0.
  - Default DATA_W and K.
  - Function win_bits(K,CH,DATA_W).
- One sub-module, conv_window_bank: storage, metadata and full flag for one bank, with write-enable, index, capture and clear inputs. It is instantiated twice. The top level holds the pointers, fill_idx, the handshakes and win_count.

## Test plan
- K=3, CH=1: stream elements 0x10..0x18 with the centre carrying row 5, col 7 and edge 4'b1000, out_ready=1. Expect out_valid one cycle after the ninth element, out_window=0x101112131415161718, row 5, col 7, edge 4'b1000, and win_count=1.
- Back-to-back streaming with out_ready=0: in_ready falls after 18 accepted elements. Raise out_ready for one cycle: the first window is emitted, then in_ready=1 on the next cycle, and the second window holds stable.
- Completion and consume in the same cycle, with continuous streaming and out_ready=1: zero bubbles occur, and in_valid stays accepted for 45 consecutive elements, producing 5 windows.
- flush after 4 elements, then 9 new elements: the output contains only the new 9 elements and the metadata of the new centre.
- Deassert reset mid-fill with one bank full: afterwards out_valid=0, win_count=0, and the next 9 elements form a clean window. Also check K=5, CH=3 packing: element 0, channel 0 occupies the top DATA_W bits.

Source files
------------

// File: rtl/conv_window_buffer_pkg.sv
// Shared constants and helpers for the convolution window buffer slice.
package conv_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_K      = 3;
  localparam int EDGE_W     = 4;

  // Bit positions inside the 4-bit edge flag word
  localparam int ZERO_ROW  = 3;
  localparam int FINAL_ROW = 2;
  localparam int ZERO_COL  = 1;
  localparam int FINAL_COL = 0;

  function automatic int win_bits(input int k, input int ch, input int data_w);
    return k * k * ch * data_w;
  endfunction
endpackage

// File: rtl/conv_window_buffer_if.sv
// Element input stream and packed-window output stream of the window buffer.
interface conv_window_buffer_if
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int K       = DEF_K,
  parameter int CH      = 1,
  parameter int COORD_W = 15
) ();
  localparam int WIN_W = win_bits(K, CH, DATA_W);

  logic                   in_valid;
  logic                   in_ready;
  logic [CH*DATA_W-1:0]   in_data;
  logic [COORD_W-1:0]     in_row;
  logic [COORD_W-1:0]     in_col;
  logic [EDGE_W-1:0]      in_edge;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIN_W-1:0]       out_window;
  logic [COORD_W-1:0]     out_row;
  logic [COORD_W-1:0]     out_col;
  logic [EDGE_W-1:0]      out_edge;

  modport master (
    output in_valid, in_data, in_row, in_col, in_edge, flush, out_ready,
    input  in_ready, out_valid, out_window, out_row, out_col, out_edge
  );

  modport slave (
    input  in_valid, in_data, in_row, in_col, in_edge, flush, out_ready,
    output in_ready, out_valid, out_window, out_row, out_col, out_edge
  );
endinterface

// File: rtl/conv_window_bank.sv
// One bank of window storage: K*K elements, captured centre metadata, full flag.
module conv_window_bank
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int K       = DEF_K,
  parameter int CH      = 1,
  parameter int COORD_W = 15,
  localparam int ELEM_W = CH * DATA_W,
  localparam int NE     = K * K,
  localparam int IDX_W  = $clog2(NE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [ELEM_W-1:0]    wr_data,
  input  logic                 cap_en,
  input  logic [COORD_W-1:0]   cap_row,
  input  logic [COORD_W-1:0]   cap_col,
  input  logic [EDGE_W-1:0]    cap_edge,
  input  logic                 discard,
  input  logic                 set_full,
  input  logic                 clr_full,
  output logic                 full,
  output logic [NE*ELEM_W-1:0] window,
  output logic [COORD_W-1:0]   row,
  output logic [COORD_W-1:0]   col,
  output logic [EDGE_W-1:0]    edge_flags
);
  // Ascending packed range puts element 0 in the MSBs of the window word
  logic [0:NE-1][ELEM_W-1:0] mem;

  assign window = mem;

  // Storage is deliberately not reset; the top gates the output word by full
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full       <= 1'b0;
      row        <= '0;
      col        <= '0;
      edge_flags <= '0;
    end else begin
      if (cap_en) begin
        row        <= cap_row;
        col        <= cap_col;
        edge_flags <= cap_edge;
      end else if (discard) begin
        row        <= '0;
        col        <= '0;
        edge_flags <= '0;
      end
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
    end
  end
endmodule

// File: rtl/conv_window_buffer.sv
// Double-buffered KxK window store: one bank fills while the other is drained.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int K       = DEF_K,
  parameter int CH      = 1,
  parameter int COORD_W = 15,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_window_buffer_if.slave  bus,
  output logic [CNT_W-1:0]     win_count
);
  localparam int NE     = K * K;
  localparam int CTR    = (NE - 1) / 2;
  localparam int IDX_W  = $clog2(NE);
  localparam int ELEM_W = CH * DATA_W;
  localparam int WIN_W  = win_bits(K, CH, DATA_W);

  generate
    if ((K < 3) || (K % 2 == 0)) begin : g_bad_k
      $error("conv_window_buffer: K must be odd and >= 3");
    end
  endgenerate

  logic                          wr_bank, rd_bank;
  logic [IDX_W-1:0]              fill_idx;
  logic [1:0]                    full;
  logic [1:0][WIN_W-1:0]         bank_win;
  logic [1:0][COORD_W-1:0]       bank_row, bank_col;
  logic [1:0][EDGE_W-1:0]        bank_edge;
  logic                          accept, last, consume;

  assign bus.in_ready = reset && !full[wr_bank];
  assign bus.out_valid = full[rd_bank];

  // An element offered alongside flush is dropped
  assign accept  = bus.in_valid && bus.in_ready && !bus.flush;
  assign last    = (fill_idx == IDX_W'(NE - 1));
  assign consume = bus.out_valid && bus.out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sel_wr, sel_rd;
    assign sel_wr = (wr_bank == 1'(b));
    assign sel_rd = (rd_bank == 1'(b));

    conv_window_bank #(
      .DATA_W (DATA_W),
      .K      (K),
      .CH     (CH),
      .COORD_W(COORD_W)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (accept && sel_wr),
      .wr_idx    (fill_idx),
      .wr_data   (bus.in_data),
      .cap_en    (accept && sel_wr && (fill_idx == IDX_W'(CTR))),
      .cap_row   (bus.in_row),
      .cap_col   (bus.in_col),
      .cap_edge  (bus.in_edge),
      .discard   (bus.flush && sel_wr && !full[b]),
      .set_full  (accept && sel_wr && last),
      .clr_full  (consume && sel_rd),
      .full      (full[b]),
      .window    (bank_win[b]),
      .row       (bank_row[b]),
      .col       (bank_col[b]),
      .edge_flags(bank_edge[b])
    );
  end

  assign bus.out_window = full[rd_bank] ? bank_win[rd_bank] : '0;
  assign bus.out_row    = bank_row[rd_bank];
  assign bus.out_col    = bank_col[rd_bank];
  assign bus.out_edge   = bank_edge[rd_bank];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      fill_idx  <= '0;
      win_count <= '0;
    end else begin
      if (bus.flush) begin
        fill_idx <= '0;
      end else if (accept) begin
        if (last) begin
          fill_idx <= '0;
          wr_bank  <= ~wr_bank;
        end else begin
          fill_idx <= fill_idx + 1'b1;
        end
      end
      if (consume) begin
        rd_bank   <= ~rd_bank;
        win_count <= win_count + 1'b1;
      end
    end
  end

  logic unused_elem_w;
  assign unused_elem_w = (ELEM_W == 0);
endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer (K=3/CH=1 main instance, K=5/CH=3 packing instance).
module tb_conv_window_buffer;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_window_buffer_if #(.DATA_W(8), .K(3), .CH(1), .COORD_W(15)) b3 ();
  conv_window_buffer_if #(.DATA_W(8), .K(5), .CH(3), .COORD_W(15)) b5 ();
  logic [15:0] wc3, wc5;

  conv_window_buffer #(.DATA_W(8), .K(3), .CH(1), .COORD_W(15), .CNT_W(16)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3), .win_count(wc3)
  );
  conv_window_buffer #(.DATA_W(8), .K(5), .CH(3), .COORD_W(15), .CNT_W(16)) u_dut5 (
    .clk(clk), .reset(reset), .bus(b5), .win_count(wc5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int stalls  = 0;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected K=3 CH=1 window whose elements are base, base+1, ... base+8
  function automatic logic [639:0] exp_win3(input logic [7:0] base);
    logic [639:0] w = '0;
    for (int i = 0; i < 9; i++) w = (w << 8) | 640'(8'(base + 8'(i)));
    return w;
  endfunction

  task automatic send3(input logic [7:0] d, input logic [14:0] r, input logic [14:0] c,
                       input logic [3:0] e);
    int w = 0;
    @(negedge clk);
    b3.in_valid = 1'b1; b3.in_data = d; b3.in_row = r; b3.in_col = c; b3.in_edge = e;
    while (!b3.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w > 0) stalls++;
    if (w >= 50) chk("send3_timeout", 640'(w), 640'd0);
    @(posedge clk);
  endtask

  // Centre element (index 4) carries real metadata; the rest carry junk
  task automatic win3(input logic [7:0] base, input logic [14:0] r, input logic [14:0] c,
                      input logic [3:0] e);
    for (int i = 0; i < 9; i++)
      if (i == 4) send3(8'(base + 8'(i)), r, c, e);
      else        send3(8'(base + 8'(i)), 15'h7fff, 15'h7fff, 4'hf);
  endtask

  task automatic idle3();
    @(negedge clk);
    b3.in_valid = 1'b0;
  endtask

  initial begin
    logic [639:0] exp5;
    b3.in_valid = 0; b3.in_data = 0; b3.in_row = 0; b3.in_col = 0; b3.in_edge = 0;
    b3.flush = 0; b3.out_ready = 0;
    b5.in_valid = 0; b5.in_data = 0; b5.in_row = 0; b5.in_col = 0; b5.in_edge = 0;
    b5.flush = 0; b5.out_ready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 640'(b3.in_ready), 640'd0);
    chk("rst_out_valid", 640'(b3.out_valid), 640'd0);
    chk("rst_out_window", 640'(b3.out_window), 640'd0);
    chk("rst_out_meta", 640'({b3.out_row, b3.out_col, b3.out_edge}), 640'd0);
    chk("rst_win_count", 640'(wc3), 640'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 640'(b3.in_ready), 640'd1);

    // Single window, consumer always ready
    b3.out_ready = 1'b1;
    win3(8'h10, 15'd5, 15'd7, 4'b1000);
    idle3();
    chk("t1_out_valid", 640'(b3.out_valid), 640'd1);
    chk("t1_window", 640'(b3.out_window), 640'h101112131415161718);
    chk("t1_row", 640'(b3.out_row), 640'd5);
    chk("t1_col", 640'(b3.out_col), 640'd7);
    chk("t1_edge", 640'(b3.out_edge), 640'(4'b1000));
    @(negedge clk);
    chk("t1_win_count", 640'(wc3), 640'd1);
    chk("t1_valid_drop", 640'(b3.out_valid), 640'd0);
    chk("t1_window_zero", 640'(b3.out_window), 640'd0);

    // Both banks fill while the consumer stalls
    b3.out_ready = 1'b0;
    stalls = 0;
    win3(8'h20, 15'd1, 15'd1, 4'b0000);
    win3(8'h29, 15'd2, 15'd2, 4'b0000);
    idle3();
    chk("t2_no_stall_18", 640'(stalls), 640'd0);
    chk("t2_in_ready_low", 640'(b3.in_ready), 640'd0);
    chk("t2_first_window", 640'(b3.out_window), exp_win3(8'h20));
    b3.out_ready = 1'b1;
    @(negedge clk);
    b3.out_ready = 1'b0;
    chk("t2_in_ready_back", 640'(b3.in_ready), 640'd1);
    chk("t2_second_valid", 640'(b3.out_valid), 640'd1);
    chk("t2_second_window", 640'(b3.out_window), exp_win3(8'h29));
    chk("t2_second_row", 640'(b3.out_row), 640'd2);
    chk("t2_win_count", 640'(wc3), 640'd2);
    @(negedge clk);
    chk("t2_hold_window", 640'(b3.out_window), exp_win3(8'h29));
    chk("t2_hold_valid", 640'(b3.out_valid), 640'd1);
    b3.out_ready = 1'b1;
    @(negedge clk);
    chk("t2_drain", 640'(wc3), 640'd3);

    // Continuous streaming: 45 elements, 5 windows, no bubbles
    stalls = 0;
    for (int w = 0; w < 5; w++) win3(8'(8'h80 + 8'(9 * w)), 15'(w), 15'(w), 4'b0000);
    idle3();
    repeat (2) @(negedge clk);
    chk("t3_stalls", 640'(stalls), 640'd0);
    chk("t3_win_count", 640'(wc3), 640'd8);

    // Flush a partial window; the offered element during flush is dropped
    b3.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send3(8'(8'h50 + 8'(i)), 15'd9, 15'd9, 4'hf);
    @(negedge clk);
    b3.flush = 1'b1; b3.in_valid = 1'b1; b3.in_data = 8'hee;
    chk("t4_flush_ready", 640'(b3.in_ready), 640'd1);
    @(negedge clk);
    b3.flush = 1'b0; b3.in_valid = 1'b0;
    win3(8'h60, 15'd3, 15'd4, 4'b0001);
    idle3();
    chk("t4_valid", 640'(b3.out_valid), 640'd1);
    chk("t4_window", 640'(b3.out_window), exp_win3(8'h60));
    chk("t4_meta", 640'({b3.out_row, b3.out_col, b3.out_edge}),
        640'({15'd3, 15'd4, 4'b0001}));
    b3.out_ready = 1'b1;
    @(negedge clk);
    b3.out_ready = 1'b0;
    chk("t4_win_count", 640'(wc3), 640'd9);

    // Reset with one bank full and another part-filled
    win3(8'h40, 15'd8, 15'd8, 4'b0000);
    for (int i = 0; i < 3; i++) send3(8'(8'h49 + 8'(i)), 15'd0, 15'd0, 4'h0);
    idle3();
    chk("t5_pre_valid", 640'(b3.out_valid), 640'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_in_ready", 640'(b3.in_ready), 640'd0);
    chk("t5_rst_valid", 640'(b3.out_valid), 640'd0);
    chk("t5_rst_window", 640'(b3.out_window), 640'd0);
    chk("t5_rst_count", 640'(wc3), 640'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rel_in_ready", 640'(b3.in_ready), 640'd1);
    win3(8'h70, 15'd1, 15'd2, 4'b0100);
    idle3();
    chk("t5_valid", 640'(b3.out_valid), 640'd1);
    chk("t5_window", 640'(b3.out_window), exp_win3(8'h70));
    chk("t5_meta", 640'({b3.out_row, b3.out_col, b3.out_edge}),
        640'({15'd1, 15'd2, 4'b0100}));

    // K=5 CH=3 packing: element e channel c carries byte 3e+c
    exp5 = '0;
    for (int e = 0; e < 25; e++) begin
      int w = 0;
      @(negedge clk);
      b5.in_valid = 1'b1;
      b5.in_data  = {8'(3 * e), 8'(3 * e + 1), 8'(3 * e + 2)};
      b5.in_row   = (e == 12) ? 15'd11 : 15'h7fff;
      b5.in_col   = (e == 12) ? 15'd22 : 15'h7fff;
      b5.in_edge  = (e == 12) ? 4'(1 << ZERO_COL) : 4'hf;
      exp5 = (exp5 << 24) | 640'({8'(3 * e), 8'(3 * e + 1), 8'(3 * e + 2)});
      while (!b5.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) chk("k5_timeout", 640'(w), 640'd0);
      @(posedge clk);
    end
    @(negedge clk);
    b5.in_valid = 1'b0;
    chk("k5_valid", 640'(b5.out_valid), 640'd1);
    chk("k5_top_elem", 640'(b5.out_window[599:576]), 640'h000102);
    chk("k5_bot_elem", 640'(b5.out_window[23:0]), 640'h48494a);
    chk("k5_window", 640'(b5.out_window), exp5);
    chk("k5_meta", 640'({b5.out_row, b5.out_col, b5.out_edge}),
        640'({15'd11, 15'd22, 4'b0010}));
    b5.out_ready = 1'b1;
    @(negedge clk);
    b5.out_ready = 1'b0;
    chk("k5_win_count", 640'(wc5), 640'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
